// File: rtl/lif_step_scheduler.sv
// Shares one leaky-integrate-and-fire update datapath across N_NEURONS neurons,
// updating one neuron per cycle after each accepted step request.
//
// state  | meaning
// IDLE   | waiting for step_req with ena high; accept latches currents
// UPDATE | one neuron per cycle, idx 0 .. N_NEURONS-1
// DONE   | one cycle with step_done high and spikes holding the new vector
module lif_step_scheduler #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 200,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRACT    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           step_req,
    input  logic [N_NEURONS*WIDTH-1:0]     cur_in,
    input  logic [$clog2(N_NEURONS)-1:0]   probe_sel,
    output logic                           busy,
    output logic                           step_done,
    output logic [N_NEURONS-1:0]           spikes,
    output logic [WIDTH-1:0]               probe_v
);
    localparam int IW = $clog2(N_NEURONS);
    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
    localparam logic [WIDTH:0]  THR    = (WIDTH+1)'(THRESHOLD);
    localparam logic [RW-1:0]   R_LOAD = RW'(REFRACT);
    localparam logic [IW-1:0]   LAST   = IW'(N_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t               state;
    logic [IW-1:0]        idx;
    logic [WIDTH-1:0]     v_mem   [N_NEURONS];
    logic [RW-1:0]        r_mem   [N_NEURONS];
    logic [WIDTH-1:0]     cur_cap [N_NEURONS];
    logic [N_NEURONS-1:0] scratch;

    logic [WIDTH-1:0]     v_cur, i_cur, sat, v_next;
    logic [RW-1:0]        r_cur, r_next;
    logic [WIDTH:0]       sum;
    logic                 fire;
    logic [N_NEURONS-1:0] scratch_next;

    // Datapath for the neuron selected by idx.
    always_comb begin
        v_cur  = v_mem[idx];
        r_cur  = r_mem[idx];
        i_cur  = cur_cap[idx];
        sum    = {1'b0, v_cur} - {1'b0, v_cur >> LEAK_SHIFT} + {1'b0, i_cur};
        sat    = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        fire   = 1'b0;
        v_next = sat;
        r_next = r_cur;
        if (r_cur != '0) begin
            r_next = r_cur - RW'(1);
            v_next = '0;
        end else if ({1'b0, sat} >= THR) begin
            fire   = 1'b1;
            v_next = '0;
            r_next = R_LOAD;
        end
        scratch_next      = scratch;
        scratch_next[idx] = fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            spikes    <= '0;
            scratch   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i]   <= '0;
                r_mem[i]   <= '0;
                cur_cap[i] <= '0;
            end
        end else begin
            step_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (step_req && ena) begin
                        state   <= UPDATE;
                        idx     <= '0;
                        busy    <= 1'b1;
                        scratch <= '0;
                        for (int i = 0; i < N_NEURONS; i++)
                            cur_cap[i] <= cur_in[i*WIDTH +: WIDTH];
                    end
                end
                UPDATE: begin
                    v_mem[idx] <= v_next;
                    r_mem[idx] <= r_next;
                    scratch    <= scratch_next;
                    if (idx == LAST) begin
                        // spikes and step_done register on the edge into DONE
                        // so both are visible during the DONE cycle.
                        state     <= DONE;
                        busy      <= 1'b0;
                        spikes    <= scratch_next;
                        step_done <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign probe_v = (int'(probe_sel) < N_NEURONS) ? v_mem[probe_sel] : '0;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Scoreboard bench for lif_step_scheduler: stimulus pushes model results,
// a monitor pops and compares on every step_done.
module tb_lif_step_scheduler;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int THR   = 200;
    localparam int LEAK  = 1;
    localparam int REFR  = 2;
    localparam int VMAX  = 255;

    logic         clk = 1'b0;
    logic         rst, ena, step_req;
    logic [31:0]  cur_in;
    logic [1:0]   probe_sel;
    logic         busy, step_done;
    logic [3:0]   spikes;
    logic [7:0]   probe_v;

    lif_step_scheduler #(
        .N_NEURONS(N), .WIDTH(W), .THRESHOLD(THR), .LEAK_SHIFT(LEAK), .REFRACT(REFR)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .step_req(step_req), .cur_in(cur_in),
        .probe_sel(probe_sel), .busy(busy), .step_done(step_done),
        .spikes(spikes), .probe_v(probe_v)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int mv [N];
    int mr [N];

    typedef struct packed {
        logic [3:0]  sp;
        logic [31:0] v;
        logic [31:0] done_cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            mr[i] = 0;
        end
    endtask

    task automatic model_step(input logic [31:0] cur, output logic [3:0] sp);
        int s;
        for (int i = 0; i < N; i++) begin
            sp[i] = 1'b0;
            if (mr[i] > 0) begin
                mr[i]--;
                mv[i] = 0;
            end else begin
                s = mv[i] - mv[i] / (1 << LEAK) + int'(cur[i*W +: W]);
                if (s > VMAX) s = VMAX;
                if (s >= THR) begin
                    sp[i] = 1'b1;
                    mv[i] = 0;
                    mr[i] = REFR;
                end else begin
                    mv[i] = s;
                end
            end
        end
    endtask

    // Monitor: every step_done must match the oldest pending expectation.
    initial begin
        exp_t        e;
        logic [31:0] ev;
        forever begin
            @(negedge clk);
            if (!rst && step_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_step_done", 1, 0);
                end else begin
                    e  = sb.pop_front();
                    ev = e.v;
                    check("spikes", int'(spikes), int'(e.sp));
                    check("probe_v_at_done", int'(probe_v), int'(ev[int'(probe_sel)*8 +: 8]));
                    check("done_latency", cyc, int'(e.done_cyc));
                end
            end
        end
    end

    task automatic do_step(input logic [31:0] cur, input logic [1:0] psel, input bit drop);
        logic [3:0] sp;
        exp_t       e;
        int         k;
        @(negedge clk);
        probe_sel = psel;
        cur_in    = cur;
        ena       = 1'b1;
        step_req  = 1'b1;
        model_step(cur, sp);
        e.sp = sp;
        for (int i = 0; i < N; i++) e.v[i*8 +: 8] = 8'(mv[i]);
        e.done_cyc = 32'(cyc + 1 + N);
        sb.push_back(e);
        @(negedge clk);
        step_req = 1'b0;
        cur_in   = $urandom;
        check("busy_during_step", int'(busy), 1);
        if (drop) begin
            step_req = 1'b1;
            @(negedge clk);
            step_req = 1'b0;
        end
        k = 0;
        while (!step_done && k < 3 * N) begin
            @(negedge clk);
            k++;
        end
        check("step_done_arrived", int'(step_done), 1);
        if (!step_done) sb.delete();
        @(negedge clk);
    endtask

    task automatic probe_all(input string tag);
        for (int i = 0; i < N; i++) begin
            probe_sel = 2'(i);
            #1;
            check(tag, int'(probe_v), mv[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        step_req = 1'b1;
        ena      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        step_req = 1'b0;
        model_clear();
        sb.delete();
        @(negedge clk);
        check("busy_after_reset_req", int'(busy), 0);
    endtask

    initial begin
        int leak_exp [4] = '{100, 150, 175, 188};
        int refr_v   [6] = '{150, 0, 0, 0, 150, 0};
        int refr_sp  [6] = '{0, 1, 0, 0, 0, 1};

        rst = 1'b1; ena = 1'b0; step_req = 1'b0; cur_in = '0; probe_sel = '0;
        model_clear();
        do_reset();
        check("reset_spikes", int'(spikes), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_step_done", int'(step_done), 0);
        probe_all("reset_probe_v");

        for (int s = 0; s < 4; s++) begin
            do_step(32'd100, 2'd0, 1'b0);
            probe_sel = 2'd0;
            #1;
            check("leak_v", int'(probe_v), leak_exp[s]);
            check("leak_spikes", int'(spikes), 0);
        end

        do_reset();
        for (int s = 0; s < 6; s++) begin
            do_step(32'd150 << 8, 2'd1, s == 1);
            probe_sel = 2'd1;
            #1;
            check("refract_v", int'(probe_v), refr_v[s]);
            check("refract_spike", int'(spikes[1]), refr_sp[s]);
        end

        do_reset();
        do_step(32'd120 << 16, 2'd2, 1'b0);
        probe_sel = 2'd2;
        #1;
        check("sat_v_step1", int'(probe_v), 120);
        do_step(32'd255 << 16, 2'd2, 1'b0);
        probe_sel = 2'd2;
        #1;
        check("sat_v_step2", int'(probe_v), 0);
        check("sat_spikes", int'(spikes), 4);

        // Request with ena low must not start a step.
        @(negedge clk);
        ena = 1'b0;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        ena = 1'b1;
        check("ena_low_busy", int'(busy), 0);
        repeat (N + 3) @(negedge clk);

        // Reset two cycles into a step aborts it without step_done.
        @(negedge clk);
        cur_in = $urandom;
        ena = 1'b1;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check("midreset_busy", int'(busy), 0);
        check("midreset_step_done", int'(step_done), 0);
        check("midreset_spikes", int'(spikes), 0);
        probe_all("midreset_probe_v");
        repeat (N + 3) @(negedge clk);

        for (int s = 0; s < 40; s++) begin
            do_step($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
            probe_all("rand_probe_v");
        end

        repeat (N + 3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
